// File: rtl/duty_selector_pkg.sv
// duty_selector_pkg: selector FSM state type and width helpers
// shared by duty_selector and pwm_core.
package duty_selector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } sel_state_e;

    // $clog2 that never collapses to a zero-width vector
    function automatic int min1_clog2(input longint n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int steps);
        return min1_clog2(longint'(steps));
    endfunction

    function automatic int cnt_width(input int period);
        return min1_clog2(longint'(period));
    endfunction

    function automatic int duty_width(input int period);
        return min1_clog2(longint'(period) + 1);
    endfunction

    function automatic int step_width(input int step);
        return min1_clog2(longint'(step) + 1);
    endfunction

    function automatic int rpt_width(input int cycles);
        return min1_clog2(longint'(cycles));
    endfunction

endpackage

// File: rtl/duty_selector_pwm_core.sv
// pwm_core: free-running period counter, per-period duty latch
// and registered PWM comparator.
module pwm_core
    import duty_selector_pkg::*;
#(
    parameter int PERIOD = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [duty_width(PERIOD)-1:0] duty_in,
    input  logic                          load_en,
    output logic                          pwm_out,
    output logic                          period_start
);

    localparam int CW = cnt_width(PERIOD);
    localparam int DW = duty_width(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [DW-1:0] duty_active_q;
    logic [DW-1:0] duty_active_d;
    logic          pwm_q;
    logic          pwm_d;
    logic          wrap;

    always_comb begin
        wrap          = (cnt_q == CNT_LAST);
        cnt_d         = wrap ? '0 : cnt_q + CW'(1);
        // Duty only changes on the period boundary.
        duty_active_d = duty_active_q;
        if (wrap && load_en) begin
            duty_active_d = duty_in;
        end
        pwm_d         = (DW'(cnt_q) < duty_active_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = (cnt_q == '0);

endmodule

// File: rtl/duty_selector.sv
// duty_selector: push-button PWM duty-level stepper.
// Define DUTY_SELECTOR_AUTOREPEAT_EN to build hold-to-repeat.
module duty_selector
    import duty_selector_pkg::*;
#(
    parameter int PERIOD        = 100,
    parameter int STEPS         = 5,
    parameter int DUTY_STEP     = 25,
    parameter int REPEAT_CYCLES = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       EN_Selector,
    output logic                       pwm_out,
    output logic [idx_width(STEPS)-1:0] duty_idx,
    output logic                       step_pulse,
    output logic                       period_start
);

    localparam int IW = idx_width(STEPS);
    localparam int DW = duty_width(PERIOD);
    localparam int SW = step_width(DUTY_STEP);
    localparam int PW = IW + SW;
    localparam logic [IW-1:0] IDX_LAST = IW'(STEPS - 1);

    if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
        $error("duty_selector: PERIOD outside 2..65535");
    end
    if (STEPS < 2 || STEPS > 16) begin : g_bad_steps
        $error("duty_selector: STEPS outside 2..16");
    end
    if (DUTY_STEP < 0) begin : g_bad_step
        $error("duty_selector: DUTY_STEP negative");
    end
    if (longint'(STEPS - 1) * longint'(DUTY_STEP) > longint'(PERIOD)) begin : g_bad_range
        $error("duty_selector: top duty exceeds PERIOD");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("duty_selector: REPEAT_CYCLES must be >= 1");
    end

    sel_state_e    state_q;
    sel_state_e    state_d;
    logic          btn_q;
    logic          btn_d;
    logic [IW-1:0] duty_idx_q;
    logic [IW-1:0] duty_idx_d;
    logic          step_pulse_q;
    logic          step_pulse_d;
    logic          press;
    logic          advance;
    logic [PW-1:0] duty_prod;
    logic [DW-1:0] duty_val;

    assign press = EN_Selector && !btn_q;

`ifdef DUTY_SELECTOR_AUTOREPEAT_EN
    localparam int RW = rpt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_d;
    logic          rpt_hit;

    assign rpt_hit = (rpt_q == RPT_LAST);

    always_comb begin
        rpt_d = rpt_q;
        if (state_q == IDLE || !EN_Selector || rpt_hit) begin
            rpt_d = '0;
        end else begin
            rpt_d = rpt_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!EN_Selector) begin
                    state_d = IDLE;
`ifdef DUTY_SELECTOR_AUTOREPEAT_EN
                end else if (rpt_hit) begin
                    state_d = REPEAT;
`endif
                end
            end
`ifdef DUTY_SELECTOR_AUTOREPEAT_EN
            REPEAT: begin
                if (!EN_Selector) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            IDLE: advance = press;
`ifdef DUTY_SELECTOR_AUTOREPEAT_EN
            HELD, REPEAT: advance = EN_Selector && rpt_hit;
`endif
            default: advance = 1'b0;
        endcase
    end

    always_comb begin
        btn_d        = EN_Selector;
        step_pulse_d = advance;
        duty_idx_d   = duty_idx_q;
        if (advance) begin
            duty_idx_d = (duty_idx_q == IDX_LAST) ? '0 : duty_idx_q + IW'(1);
        end
    end

    // btn_q resets high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q        <= 1'b1;
            duty_idx_q   <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            btn_q        <= btn_d;
            duty_idx_q   <= duty_idx_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Full-width product; the range check above makes the narrowing lossless.
    assign duty_prod = PW'(duty_idx_q) * PW'(DUTY_STEP);
    assign duty_val  = DW'(duty_prod);

    pwm_core #(
        .PERIOD(PERIOD)
    ) u_pwm_core (
        .clk         (clk),
        .rst         (rst),
        .duty_in     (duty_val),
        .load_en     (1'b1),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    assign duty_idx   = duty_idx_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_duty_selector.sv
// tb_duty_selector: directed scenarios plus random button traffic,
// checked every cycle against a period/level reference model.
`timescale 1ns/1ps
module tb_duty_selector;

    localparam int P  = 8;
    localparam int S  = 5;
    localparam int DS = 2;
    localparam int RC = 10;

`ifdef DUTY_SELECTOR_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pwm_out;
    logic       step_pulse;
    logic       period_start;
    logic [2:0] duty_idx;

    int vectors     = 0;
    int miscompares = 0;
    int step_seen   = 0;

    always #5 clk = ~clk;

    duty_selector #(
        .PERIOD(P),
        .STEPS(S),
        .DUTY_STEP(DS),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .EN_Selector (en),
        .pwm_out     (pwm_out),
        .duty_idx    (duty_idx),
        .step_pulse  (step_pulse),
        .period_start(period_start)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_t is cycles since reset, so the counter is m_t % P.
    int m_t;
    int m_idx;
    int m_duty;
    int m_hold;
    bit m_prev;
    bit m_held;
    bit m_valid = 1'b0;
    bit e_pwm;
    bit e_step;

    always @(posedge clk) begin
        bit adv;
        if (rst) begin
            m_t = 0; m_idx = 0; m_duty = 0; m_hold = 0;
            m_prev = 1'b1; m_held = 1'b0;
            e_pwm = 1'b0; e_step = 1'b0;
            m_valid = 1'b1;
        end else begin
            e_pwm = ((m_t % P) < m_duty);
            if ((m_t % P) == P - 1) m_duty = m_idx * DS;
            m_t++;
            adv = en && !m_prev;
            if (!en) begin
                m_held = 1'b0;
                m_hold = 0;
            end else if (adv) begin
                m_held = 1'b1;
                m_hold = 0;
            end else if (m_held && AR) begin
                m_hold++;
                if (m_hold % RC == 0) adv = 1'b1;
            end
            if (adv) m_idx = (m_idx + 1) % S;
            e_step = adv;
            m_prev = en;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pwm_out", pwm_out, e_pwm);
            chk("step_pulse", step_pulse, e_step);
            chk("duty_idx", duty_idx, m_idx);
            chk("period_start", period_start, (m_t % P) == 0);
        end
        if (step_pulse === 1'b1) step_seen++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold);
        en = 1'b1;
        cyc(hold);
        en = 1'b0;
        cyc(1);
    endtask

    task automatic wait_ps();
        cyc();
        for (int i = 0; i < 3 * P; i++) begin
            if (period_start === 1'b1) return;
            cyc();
        end
        vectors++;
        miscompares++;
        $display("FAIL period_start_wait: got no strobe expected one within %0d cycles", 3 * P);
    endtask

    task automatic count_high(output int h);
        h = 0;
        for (int i = 0; i < P; i++) begin
            h += int'(pwm_out === 1'b1);
            cyc();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int h;

        rst = 1'b1;
        en  = 1'b0;
        cyc(3);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_idx", duty_idx, 0);
        rst = 1'b0;
        chk("rel_period_start", period_start, 1);
        cyc(2);

        // Three spaced presses reach level 3 (duty 6 of 8).
        base = step_seen;
        repeat (3) begin
            press(2);
            cyc(20);
        end
        chk("three_steps", step_seen - base, 3);
        chk("three_idx", duty_idx, 3);
        wait_ps();
        count_high(h);
        chk("duty6_high", h, 6);

        // Level 4 is full-on, wrap to 0 is full-off.
        press(2);
        cyc(20);
        wait_ps();
        count_high(h);
        chk("lvl4_idx", duty_idx, 4);
        chk("duty8_high", h, 8);
        press(2);
        cyc(20);
        wait_ps();
        count_high(h);
        chk("wrap_idx", duty_idx, 0);
        chk("duty0_high", h, 0);

        // Mid-period press at cnt=3 while at level 1.
        press(2);
        cyc(20);
        wait_ps();
        h = 0;
        for (int i = 1; i <= P; i++) begin
            cyc();
            h += int'(pwm_out === 1'b1);
            if (i == 3) en = 1'b1;
            if (i == 5) en = 1'b0;
        end
        chk("midpress_cur_high", h, 2);
        count_high(h);
        chk("midpress_next_high", h, 4);

        // Reset at cnt=5 while at level 2.
        wait_ps();
        cyc(5);
        rst = 1'b1;
        cyc();
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_idx", duty_idx, 0);
        cyc(2);
        rst = 1'b0;
        chk("midrst_period_start", period_start, 1);
        cyc(3);

        // Button held through reset gives no step.
        en  = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        base = step_seen;
        cyc(10);
        chk("heldrst_steps", step_seen - base, 0);
        chk("heldrst_idx", duty_idx, 0);
        en = 1'b0;
        cyc(2);
        press(2);
        cyc(2);
        chk("heldrst_press_idx", duty_idx, 1);

        // Long hold: auto-repeat when built, single step otherwise.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        base = step_seen;
        en = 1'b1;
        cyc(35);
        en = 1'b0;
        cyc(3);
        chk("hold35_steps", step_seen - base, AR ? 4 : 1);
        chk("hold35_idx", duty_idx, AR ? 4 : 1);

        // Random button traffic with occasional resets.
        repeat (60) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
            en = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 25));
        end
        en = 1'b0;
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
